// File: rtl/cfg_reg_bank.sv
// Parametrised configuration register bank with error reporting and a
// shadowed export bus that only changes on COMMIT (or directly if AUTO_COMMIT).
module cfg_reg_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_EXPORT = 4,
  parameter logic [NUM_EXPORT*DATA_WIDTH-1:0] INIT_VALUES = 32'h2081_0000,
  parameter bit          AUTO_COMMIT = 1'b0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             R_REG_EN,
  input  logic                             W_REG_EN,
  input  logic [ADDR_WIDTH-1:0]            REG_ADDRESS,
  input  logic [DATA_WIDTH-1:0]            W_REG_DATA,
  input  logic                             COMMIT,
  output logic [DATA_WIDTH-1:0]            R_REG_DATA,
  output logic                             R_DATA_VALID,
  output logic                             ACCESS_ERR,
  output logic                             CFG_PENDING,
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] CFG_REGS
);

  localparam int unsigned EXP_W  = NUM_EXPORT * DATA_WIDTH;
  localparam int unsigned FULL_W = DEPTH * DATA_WIDTH;
  localparam int unsigned CMP_W  = ADDR_WIDTH + 1;
  // Zero-extended reset image: entries at or above NUM_EXPORT reset to 0.
  localparam logic [FULL_W-1:0] INIT_FULL = FULL_W'(INIT_VALUES);

  if ((DEPTH < 2) || (DEPTH > (2 ** ADDR_WIDTH)) ||
      (NUM_EXPORT < 1) || (NUM_EXPORT > DEPTH)) begin : g_bad_params
    $error("cfg_reg_bank: illegal DEPTH/NUM_EXPORT for ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [EXP_W-1:0]      export_bus;
  logic                  in_range;
  logic                  is_export;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  err;

  // Access decode
  always_comb begin
    in_range  = CMP_W'(REG_ADDRESS) < CMP_W'(DEPTH);
    is_export = CMP_W'(REG_ADDRESS) < CMP_W'(NUM_EXPORT);
    wr_ok     = W_REG_EN && !R_REG_EN && in_range;
    rd_ok     = R_REG_EN && !W_REG_EN && in_range;
    err       = (R_REG_EN || W_REG_EN) && ((R_REG_EN && W_REG_EN) || !in_range);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= INIT_FULL[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (wr_ok) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (REG_ADDRESS == ADDR_WIDTH'(k)) mem_q[k] <= W_REG_DATA;
      end
    end
  end

  for (genvar k = 0; k < int'(NUM_EXPORT); k++) begin : g_export
    assign export_bus[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
  end

  // Read data holds between reads; pulses last one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_REG_DATA   <= '0;
      R_DATA_VALID <= 1'b0;
      ACCESS_ERR   <= 1'b0;
    end else begin
      R_DATA_VALID <= rd_ok;
      ACCESS_ERR   <= err;
      if (rd_ok) R_REG_DATA <= mem_q[REG_ADDRESS];
    end
  end

  if (AUTO_COMMIT) begin : g_auto
    assign CFG_REGS    = export_bus;
    assign CFG_PENDING = 1'b0;
  end else begin : g_shadow
    logic [EXP_W-1:0] shadow_q;
    logic             pending_q;

    // Shadow captures pre-edge array contents; a same-cycle write stays pending
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        shadow_q  <= INIT_VALUES;
        pending_q <= 1'b0;
      end else begin
        if (COMMIT) shadow_q <= export_bus;
        if (wr_ok && is_export) pending_q <= 1'b1;
        else if (COMMIT)        pending_q <= 1'b0;
      end
    end

    assign CFG_REGS    = shadow_q;
    assign CFG_PENDING = pending_q;
  end

endmodule

// File: doc/cfg_reg_bank.md
Name: cfg_reg_bank

Overview:
Parametrised configuration register bank, successor to the system's fixed 16x8 register file. It adds configurable width, depth and export count, parameter-defined reset values, and a shadowed export path. Exported configuration registers change atomically on COMMIT, so downstream config consumers (ALU, UART, clock divider) never see half-updated settings. It also adds out-of-range and illegal-access error reporting, and sits behind the system controller on the reference clock domain.

Parameters:
DATA_WIDTH, 8, register width in bits
ADDR_WIDTH, 4, address bus width
DEPTH, 16, number of implemented registers (2..2^ADDR_WIDTH)
NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 exported on CFG_REGS (1..DEPTH)
INIT_VALUES, 32'h2081_0000, NUM_EXPORT*DATA_WIDTH reset values; slice k = register k (default: reg2=0x81, reg3=0x20, others 0)
AUTO_COMMIT, 0, 1 = export bypasses shadow (legacy behaviour)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset, asynchronous, active-high
R_REG_EN  in  1  read request, sampled per cycle
W_REG_EN  in  1  write request, sampled per cycle
REG_ADDRESS  in  ADDR_WIDTH  access address
W_REG_DATA  in  DATA_WIDTH  write data
COMMIT  in  1  single-cycle pulse: copy export registers to shadow
R_REG_DATA  out  DATA_WIDTH  read data, registered
R_DATA_VALID  out  1  one-cycle pulse qualifying R_REG_DATA
ACCESS_ERR  out  1  one-cycle pulse on rejected access
CFG_PENDING  out  1  export register written since last commit
CFG_REGS  out  NUM_EXPORT*DATA_WIDTH  shadowed export bus, slice k = register k

Behaviour:
- Reset (RST=1, async, takes effect immediately, including mid-access):
  - array[k] = INIT_VALUES slice k for k<NUM_EXPORT; all other entries 0.
  - Shadow = INIT_VALUES.
  - R_REG_DATA=0, R_DATA_VALID=0, ACCESS_ERR=0, CFG_PENDING=0.
- Legal write (W=1, R=0, addr<DEPTH): array[addr] updates at the edge, R_DATA_VALID=0 next cycle. If addr<NUM_EXPORT, CFG_PENDING sets at the same edge.
- Legal read (R=1, W=0, addr<DEPTH): at the next edge R_REG_DATA=array[addr] and R_DATA_VALID=1 for exactly one cycle. Latency is 1 cycle. Back-to-back reads give back-to-back valid pulses.
- Write then read to the same address in consecutive cycles: the read returns the new data (no bypass needed, since the write has already landed).
- R_REG_DATA holds its last read value when no read is in progress. It is not zeroed, unlike the predecessor.
- R=1 and W=1 together: no array change, R_DATA_VALID=0, ACCESS_ERR=1 for one cycle.
- Any R or W with addr>=DEPTH: no array change, R_DATA_VALID=0, ACCESS_ERR=1 for one cycle, R_REG_DATA holds.
- Idle (R=0, W=0): R_DATA_VALID=0, ACCESS_ERR=0.
- COMMIT (AUTO_COMMIT=0):
  - At the edge, shadow[k] = array[k] as held before that edge, for all k<NUM_EXPORT.
  - CFG_PENDING clears.
  - If a legal export write occurs in the same cycle, that write is not included in the shadow, and CFG_PENDING remains 1 (set wins).
  - COMMIT during reset is ignored.
- AUTO_COMMIT=1: CFG_REGS is driven directly from array[0..NUM_EXPORT-1] with zero latency after the write edge. COMMIT is ignored and CFG_PENDING is tied to 0.
- Write/read, commit and error are independent. Commit may coincide with any access.
- Parameter legality: DEPTH<=2^ADDR_WIDTH and NUM_EXPORT<=DEPTH. A violation fails elaboration.

Test Plan:
- Reset values: assert RST mid-write, release -> CFG_REGS=32'h2081_0000; reading addr 2 gives 0x81, addr 3 gives 0x20, addr 9 gives 0x00; all pulse outputs are 0.
- Shadow commit: write 0x5A to addr 1 -> CFG_PENDING=1, CFG_REGS slice1 still 0x00. Pulse COMMIT -> next cycle slice1=0x5A and CFG_PENDING=0.
- Simultaneous commit and write: in the COMMIT cycle, write 0x33 to addr 0 -> slice0 keeps its old value, CFG_PENDING stays 1. A second COMMIT -> slice0=0x33.
- Read timing: write 0xC3 to addr 12, read addr 12 the next cycle -> one cycle later R_REG_DATA=0xC3 and R_DATA_VALID=1 for exactly one cycle. Afterwards R_REG_DATA holds 0xC3 with valid=0.
- Errors (DEPTH=12 build): read addr 13 -> ACCESS_ERR one cycle, valid=0. R=W=1 at addr 5 with data 0xFF -> ACCESS_ERR=1, and a subsequent read of addr 5 returns its prior value.
- AUTO_COMMIT=1 build: write 0x7E to addr 3 -> CFG_REGS slice3=0x7E right after the write edge, with no COMMIT and CFG_PENDING constant 0.
